pagerank_test_mem_responder: RTL
================================

// Module: pagerank_test_mem_responder
// PURPOSE
// - Responder end of the two-port VC memory interface driven by the PageRank scheduler.
// - Holds a word-addressed register-array memory and serves read, write and init requests on two independent ports.
// - Returns one response per accepted request, in order per port.
// - Serves as the on-chip graph/R-vector store in PageRank unit and system benches.
// PARAMETERS
// - nbits   32  data word width; must match the req/resp data field (32)
// - nwords  256 memory depth in words; power of 2, >=2
// - nports  2   port count; fixed at 2, ports 0/1 are explicit
// PORTS
// - clk            in   1   clock; all state on posedge
// - reset          in   1   asynchronous, active-high reset
// - mem_req0_msg   in   77  VC req msg {type[2:0],opaque[7:0],addr[31:0],len[1:0],data[31:0]}, MSB first
// - mem_req0_val   in   1   request valid
// - mem_req0_rdy   out  1   request ready
// - mem_resp0_msg  out  47  VC resp msg {type[2:0],opaque[7:0],test[1:0],len[1:0],data[31:0]}
// - mem_resp0_val  out  1   response valid
// - mem_resp0_rdy  in   1   response ready
// - mem_req1_*/mem_resp1_*  same as port 0, port 1
// BEHAVIOUR
// - Reset: resp val=0 on both ports; req rdy=0 while reset high; resp buffers empty.
// - Reset does not clear memory contents; mid-operation reset drops buffered responses and in-flight requests.
// - Handshake: a transfer occurs on a cycle where val&&rdy; val never depends on rdy.
// - Per port, a one-entry response buffer sets req_rdy = !full || resp_rdy (pipelined).
// - Latency: a request accepted in cycle N gives resp_val=1 in cycle N+1; full throughput of 1/cycle/port under no backpressure.
// - Index: word index = addr[log2(nwords)+1:2]; addr[1:0] ignored.
// - Out of range (addr >= 4*nwords): read data=0; write/init has no effect; a response is still sent.
// - Types:
//   - READ(0): resp data = mem[index] sampled at accept, before same-cycle writes.
//   - WRITE(1): mem[index] <= req data at accept edge; resp data=0.
//   - INIT(2): same as WRITE.
//   - Other types: no memory effect; resp data=0.
// - Response fields: type and opaque echoed from the request; test=2'b00; len=2'b00. Req len ignored (full word always).
// - Simultaneous events:
//   - Both ports write the same index in one cycle: port 1 data wins.
//   - Read on one port + write to the same index on the other port: read returns the old value.
//   - Buffer full && resp_rdy && req_val: the response dequeues and the new one enqueues in the same cycle, no bubble.
// - Backpressure: resp_rdy=0 holds resp msg/val stable; req_rdy drops while full; no request is lost or duplicated.
// - The two ports are fully independent except for the collision rules above.
// STRUCTURE
// - Shared package pagerank_mem_pkg:
//   - type constants MEM_TYPE_READ/WRITE/INIT
//   - req/resp field widths and offsets
//   - REQ_NBITS=77, RESP_NBITS=47
// - Reuse vc_MemReqMsgUnpack / vc_MemRespMsgPack for field extraction.
// - One sub-module pagerank_mem_resp_buf: one-entry pipelined response buffer with async reset, instantiated once per port.
// - Top level contains the memory array, index decode, range check, write-priority mux and read mux.
// TESTING
// - Write port0 addr 0x10 data 0xDEADBEEF, then read port0 addr 0x10 -> two responses: WRITE data 0, then READ data 0xDEADBEEF, each 1 cycle after accept.
// - Both ports write addr 0x20 in the same cycle (p0 0x1111, p1 0x2222), then read -> 0x2222.
// - Port0 reads 0x30 (old 0x5) while port1 writes 0x30=0x9 in the same cycle -> port0 read 0x5; a later read gives 0x9.
// - Hold resp0_rdy=0 for 5 cycles with back-to-back reqs -> one resp buffered and stable, req0_rdy=0 until drain, no loss; opaque 0x00..0x03 returned in order.
// - Read addr 4*nwords (0x400 for default nwords) -> resp data 0, type READ, test 00; write there leaves index 0 unchanged.
// - Assert reset while resp0_val=1 -> resp val drops immediately; after release req rdy=1 and prior memory data still readable.

Source files
------------

// File: rtl/pagerank_test_mem_responder_pkg.sv
// Purpose: shared types, field layout and message helpers for the PageRank VC memory port.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pagerank_mem_pkg;

    localparam int REQ_NBITS  = 77;
    localparam int RESP_NBITS = 47;

    localparam int TYPE_W   = 3;
    localparam int OPAQUE_W = 8;
    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 2;
    localparam int TEST_W   = 2;
    localparam int DATA_W   = 32;

    // Request field offsets (LSB positions), MSB-first packing.
    localparam int REQ_DATA_LSB   = 0;
    localparam int REQ_LEN_LSB    = REQ_DATA_LSB + DATA_W;
    localparam int REQ_ADDR_LSB   = REQ_LEN_LSB + LEN_W;
    localparam int REQ_OPAQUE_LSB = REQ_ADDR_LSB + ADDR_W;
    localparam int REQ_TYPE_LSB   = REQ_OPAQUE_LSB + OPAQUE_W;

    // Response field offsets (LSB positions).
    localparam int RESP_DATA_LSB   = 0;
    localparam int RESP_LEN_LSB    = RESP_DATA_LSB + DATA_W;
    localparam int RESP_TEST_LSB   = RESP_LEN_LSB + LEN_W;
    localparam int RESP_OPAQUE_LSB = RESP_TEST_LSB + TEST_W;
    localparam int RESP_TYPE_LSB   = RESP_OPAQUE_LSB + OPAQUE_W;

    localparam logic [TYPE_W-1:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [TYPE_W-1:0] MEM_TYPE_WRITE = 3'd1;
    localparam logic [TYPE_W-1:0] MEM_TYPE_INIT  = 3'd2;

    // Packed struct order matches the wire order, so pack/unpack are plain casts.
    typedef struct packed {
        logic [TYPE_W-1:0]   typ;
        logic [OPAQUE_W-1:0] opaque;
        logic [ADDR_W-1:0]   addr;
        logic [LEN_W-1:0]    len;
        logic [DATA_W-1:0]   data;
    } mem_req_t;

    typedef struct packed {
        logic [TYPE_W-1:0]   typ;
        logic [OPAQUE_W-1:0] opaque;
        logic [TEST_W-1:0]   test;
        logic [LEN_W-1:0]    len;
        logic [DATA_W-1:0]   data;
    } mem_resp_t;

    function automatic mem_req_t vc_mem_req_unpack(input logic [REQ_NBITS-1:0] msg);
        return mem_req_t'(msg);
    endfunction

    function automatic logic [RESP_NBITS-1:0] vc_mem_resp_pack(input mem_resp_t resp);
        return RESP_NBITS'(resp);
    endfunction

endpackage

// File: rtl/pagerank_test_mem_responder_if.sv
// Purpose: one VC memory port bundle (request + response channels, val/rdy each).
// Latency: n/a (wires only).
// Backpressure: req_rdy from responder, resp_rdy from requester.
interface pagerank_test_mem_responder_if;
    import pagerank_mem_pkg::*;

    logic [REQ_NBITS-1:0]  req_msg;
    logic                  req_val;
    logic                  req_rdy;
    logic [RESP_NBITS-1:0] resp_msg;
    logic                  resp_val;
    logic                  resp_rdy;

    // Requester side (scheduler).
    modport master (
        output req_msg, req_val, resp_rdy,
        input  req_rdy, resp_msg, resp_val
    );

    // Responder side (memory).
    modport slave (
        input  req_msg, req_val, resp_rdy,
        output req_rdy, resp_msg, resp_val
    );
endinterface

// File: rtl/pagerank_mem_resp_buf.sv
// Purpose: one-entry pipelined response buffer; enq_rdy = !full || deq_rdy.
// Latency: entry enqueued at edge N is visible on deq_* in cycle N+1.
// Backpressure: deq_rdy=0 holds deq_msg/deq_val stable; enqueue blocked while full and not draining.
// Ports: clk, reset (async active-high), enq_msg/val/rdy (in), deq_msg/val/rdy (out).
module pagerank_mem_resp_buf #(
    parameter int W = 47
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] enq_msg,
    input  logic         enq_val,
    output logic         enq_rdy,
    output logic [W-1:0] deq_msg,
    output logic         deq_val,
    input  logic         deq_rdy
);
    logic         full_q, full_d;
    logic [W-1:0] msg_q, msg_d;

    always_comb begin
        full_d  = full_q;
        msg_d   = msg_q;
        enq_rdy = !full_q || deq_rdy;
        // Enqueue takes priority: a simultaneous dequeue+enqueue leaves the buffer full.
        if (enq_val && enq_rdy) begin
            full_d = 1'b1;
            msg_d  = enq_msg;
        end else if (full_q && deq_rdy) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            msg_q  <= '0;
        end else begin
            full_q <= full_d;
            msg_q  <= msg_d;
        end
    end

    assign deq_val = full_q;
    assign deq_msg = msg_q;
endmodule

// File: rtl/pagerank_test_mem_responder.sv
// Purpose: two-port word-addressed register-array memory answering READ/WRITE/INIT requests.
// Latency: response valid one cycle after accept; 1 req/cycle/port without backpressure.
// Backpressure: per-port one-entry pipelined buffer; req_rdy = (!full || resp_rdy) && !reset.
// Ports: clk, reset, mem_req{0,1}_msg/val/rdy (77-bit requests), mem_resp{0,1}_msg/val/rdy (47-bit responses).
module pagerank_test_mem_responder
    import pagerank_mem_pkg::*;
#(
    parameter int nbits  = 32,
    parameter int nwords = 256,
    parameter int nports = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [REQ_NBITS-1:0]  mem_req0_msg,
    input  logic                  mem_req0_val,
    output logic                  mem_req0_rdy,
    output logic [RESP_NBITS-1:0] mem_resp0_msg,
    output logic                  mem_resp0_val,
    input  logic                  mem_resp0_rdy,

    input  logic [REQ_NBITS-1:0]  mem_req1_msg,
    input  logic                  mem_req1_val,
    output logic                  mem_req1_rdy,
    output logic [RESP_NBITS-1:0] mem_resp1_msg,
    output logic                  mem_resp1_val,
    input  logic                  mem_resp1_rdy
);
    localparam int IDX_W = $clog2(nwords);

    // Memory contents deliberately survive reset.
    logic [nbits-1:0] mem_q [nwords];

    logic [REQ_NBITS-1:0]  req_msg  [nports];
    logic [RESP_NBITS-1:0] resp_msg [nports];
    logic [RESP_NBITS-1:0] rsp_pkt  [nports];
    logic [IDX_W-1:0]      idx      [nports];
    logic [nbits-1:0]      rdata    [nports];
    logic [nbits-1:0]      wdata    [nports];
    mem_req_t              req      [nports];

    logic [nports-1:0] req_val, req_rdy, enq_rdy, fire;
    logic [nports-1:0] resp_val, resp_rdy, in_range, wen;

    assign req_msg[0]    = mem_req0_msg;
    assign req_msg[1]    = mem_req1_msg;
    assign req_val       = {mem_req1_val, mem_req0_val};
    assign resp_rdy      = {mem_resp1_rdy, mem_resp0_rdy};
    assign mem_req0_rdy  = req_rdy[0];
    assign mem_req1_rdy  = req_rdy[1];
    assign mem_resp0_msg = resp_msg[0];
    assign mem_resp1_msg = resp_msg[1];
    assign mem_resp0_val = resp_val[0];
    assign mem_resp1_val = resp_val[1];

    for (genvar p = 0; p < nports; p++) begin : g_port
        mem_resp_t rsp;

        assign req[p]      = vc_mem_req_unpack(req_msg[p]);
        assign req_rdy[p]  = enq_rdy[p] && !reset;
        assign fire[p]     = req_val[p] && req_rdy[p];
        assign idx[p]      = req[p].addr[IDX_W+1:2];
        // In range iff every address bit above the word index is zero.
        assign in_range[p] = (req[p].addr[ADDR_W-1:IDX_W+2] == '0);
        assign wen[p]      = fire[p] && in_range[p] &&
                             ((req[p].typ == MEM_TYPE_WRITE) || (req[p].typ == MEM_TYPE_INIT));
        assign wdata[p]    = req[p].data;

        // Combinational read of the pre-edge array: same-cycle writes are not visible.
        always_comb begin
            rdata[p] = '0;
            if ((req[p].typ == MEM_TYPE_READ) && in_range[p]) begin
                rdata[p] = mem_q[idx[p]];
            end
        end

        always_comb begin
            rsp        = '0;
            rsp.typ    = req[p].typ;
            rsp.opaque = req[p].opaque;
            rsp.data   = rdata[p];
        end

        assign rsp_pkt[p] = vc_mem_resp_pack(rsp);

        pagerank_mem_resp_buf #(.W(RESP_NBITS)) u_resp_buf (
            .clk     (clk),
            .reset   (reset),
            .enq_msg (rsp_pkt[p]),
            .enq_val (fire[p]),
            .enq_rdy (enq_rdy[p]),
            .deq_msg (resp_msg[p]),
            .deq_val (resp_val[p]),
            .deq_rdy (resp_rdy[p])
        );

        logic unused_bits;
        assign unused_bits = ^{req[p].len, req[p].addr[1:0]};
    end

    // Ports are applied in ascending order, so port 1 wins a same-index collision.
    always_ff @(posedge clk) begin
        for (int p = 0; p < nports; p++) begin
            if (wen[p]) begin
                mem_q[idx[p]] <= wdata[p];
            end
        end
    end
endmodule
